mc_main_control: RTL and testbench

- Multi-cycle main control FSM for the MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, j and addi.
- Drives aluop1/aluop0 into the ALU-control decoder, plus all datapath mux and enable strobes.
- Tolerates variable-latency memory through a mem_ready handshake with a watchdog timeout.

---
 rtl/mc_pkg.sv | 46 ++++
 rtl/mc_wait_timer.sv | 31 +++
 rtl/mc_main_control.sv | 196 +++++++++++++++++++
 tb/tb_mc_main_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS main control: opcodes, state
// encoding and the datapath select codes driven by the controller.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12
  } state_t;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // States that wait on the memory handshake and are guarded by the watchdog.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Watchdog for memory wait states: counts consecutive cycles without
// mem_ready and flags expiry on the MAX_WAIT-th such cycle.
module mc_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = active && !mem_ready && (cnt == LAST);

  // Outside wait states the counter sits at zero, so every entry starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active || mem_ready || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: Moore control strobes per state, with
// completion strobes gated by mem_ready and a watchdog abort back to FETCH.
module mc_main_control
  import mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       aluop1,
  output logic       aluop0,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  state_t     cur, nxt;
  logic       expired;
  logic [1:0] aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= ST_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  mc_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (is_wait_state(cur)),
    .mem_ready (mem_ready),
    .expired   (expired)
  );

  assign state  = cur;
  assign aluop1 = aluop[1];
  assign aluop0 = aluop[0];

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = ALUSRCB_RT;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    nxt         = ST_IDLE;

    case (cur)
      ST_IDLE: nxt = ST_FETCH;

      ST_FETCH: begin
        memread = 1'b1;
        alusrcb = ALUSRCB_FOUR;
        if (mem_ready) begin
          irwrite  = 1'b1;
          pcwrite  = 1'b1;
          pcsource = PCSRC_ALU;
          nxt      = ST_DECODE;
        end else begin
          mem_timeout = expired;
          nxt         = ST_FETCH;
        end
      end

      ST_DECODE: begin
        alusrcb = ALUSRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: nxt = ST_MEMADR;
          OP_RTYPE:     nxt = ST_EXEC;
          OP_BEQ:       nxt = ST_BRANCH;
          OP_J:         nxt = ST_JUMP;
          OP_ADDI:      nxt = ST_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            nxt        = ST_FETCH;
          end
        endcase
      end

      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        nxt     = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end

      ST_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          nxt = ST_MEMWB;
        end else if (expired) begin
          mem_timeout = 1'b1;
          nxt         = ST_FETCH;
        end else begin
          nxt = ST_MEMRD;
        end
      end

      ST_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
        nxt        = ST_FETCH;
      end

      ST_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          nxt        = ST_FETCH;
        end else if (expired) begin
          mem_timeout = 1'b1;
          nxt         = ST_FETCH;
        end else begin
          nxt = ST_MEMWR;
        end
      end

      ST_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        nxt     = ST_RWB;
      end

      ST_RWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = ST_FETCH;
      end

      ST_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        nxt         = ST_FETCH;
      end

      ST_JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = PCSRC_JUMP;
        instr_done = 1'b1;
        nxt        = ST_FETCH;
      end

      ST_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        nxt     = ST_ADDIWB;
      end

      ST_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = ST_FETCH;
      end

      default: nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed instruction sequences plus random
// opcode/handshake traffic, checked against an instruction-level queue model.
module tb_mc_main_control;
  import mc_pkg::*;

  localparam int MAX_W = 4;

  typedef struct packed {
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       instr_done, illegal_op, mem_timeout;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0;
  logic       instr_done, illegal_op, mem_timeout;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  ctl_t       g_now;

  int total = 0;
  int bad = 0;

  // Reference model: current step plus the queue of remaining steps.
  state_t m_ph;
  state_t m_q[$];
  int     m_waited;
  int     cyc, last_done, prev_done, n_tmo;

  mc_main_control #(.MAX_WAIT(MAX_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop1(aluop1), .aluop0(aluop0),
    .pcsource(pcsource), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  assign g_now = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                  memtoreg, regdst, regwrite, alusrca, alusrcb, aluop1, aluop0,
                  pcsource, instr_done, illegal_op, mem_timeout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic state_t next_from_q();
    if (m_q.size() > 0) return m_q.pop_front();
    return ST_FETCH;
  endfunction

  function automatic bit waits_on_mem(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

  task automatic model_reset();
    m_ph = ST_IDLE;
    m_q.delete();
    m_waited = 0;
    cyc = 0;
    last_done = 0;
    prev_done = 0;
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model.
  task automatic cycle(input logic [5:0] o, input logic r);
    ctl_t   e;
    state_t nx;
    bit     tmo;
    op = o;
    mem_ready = r;
    @(negedge clk);
    cyc++;
    e = '0;
    nx = ST_FETCH;
    tmo = waits_on_mem(m_ph) && !r && (m_waited == MAX_W - 1);
    case (m_ph)
      ST_IDLE: nx = ST_FETCH;
      ST_FETCH: begin
        e.memread = 1'b1; e.alusrcb = 2'b01;
        if (r) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; nx = ST_DECODE; end
        else nx = ST_FETCH;
      end
      ST_DECODE: begin
        e.alusrcb = 2'b11;
        m_q.delete();
        if (o == 6'b100011 || o == 6'b101011) m_q.push_back(ST_MEMADR);
        else if (o == 6'b000000) begin m_q.push_back(ST_EXEC); m_q.push_back(ST_RWB); end
        else if (o == 6'b000100) m_q.push_back(ST_BRANCH);
        else if (o == 6'b000010) m_q.push_back(ST_JUMP);
        else if (o == 6'b001000) begin m_q.push_back(ST_ADDIEX); m_q.push_back(ST_ADDIWB); end
        else e.illegal_op = 1'b1;
        nx = next_from_q();
      end
      ST_MEMADR: begin
        e.alusrca = 1'b1; e.alusrcb = 2'b10;
        if (o == 6'b100011) begin m_q.push_back(ST_MEMRD); m_q.push_back(ST_MEMWB); end
        else m_q.push_back(ST_MEMWR);
        nx = next_from_q();
      end
      ST_MEMRD: begin
        e.memread = 1'b1; e.iord = 1'b1;
        nx = r ? next_from_q() : ST_MEMRD;
      end
      ST_MEMWB: begin
        e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1;
        nx = next_from_q();
      end
      ST_MEMWR: begin
        e.memwrite = 1'b1; e.iord = 1'b1; e.instr_done = r;
        nx = r ? next_from_q() : ST_MEMWR;
      end
      ST_EXEC: begin e.alusrca = 1'b1; e.aluop = 2'b10; nx = next_from_q(); end
      ST_RWB: begin
        e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1; nx = next_from_q();
      end
      ST_BRANCH: begin
        e.alusrca = 1'b1; e.aluop = 2'b01; e.pcwritecond = 1'b1;
        e.pcsource = 2'b01; e.instr_done = 1'b1; nx = next_from_q();
      end
      ST_JUMP: begin
        e.pcwrite = 1'b1; e.pcsource = 2'b10; e.instr_done = 1'b1; nx = next_from_q();
      end
      ST_ADDIEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; nx = next_from_q(); end
      ST_ADDIWB: begin e.regwrite = 1'b1; e.instr_done = 1'b1; nx = next_from_q(); end
      default: nx = ST_IDLE;
    endcase
    if (tmo) begin
      e.mem_timeout = 1'b1;
      nx = ST_FETCH;
      m_q.delete();
    end
    chk("state", 32'(state), 32'(m_ph));
    chk("ctl", 32'(g_now), 32'(e));
    if (g_now.instr_done) begin prev_done = last_done; last_done = cyc; end
    if (g_now.mem_timeout) n_tmo++;
    m_waited = (waits_on_mem(m_ph) && nx == m_ph && !r && !tmo) ? m_waited + 1 : 0;
    m_ph = nx;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    op = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(g_now), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  logic [5:0] optab [0:5];

  initial begin
    optab[0] = 6'b000000; optab[1] = 6'b100011; optab[2] = 6'b101011;
    optab[3] = 6'b000100; optab[4] = 6'b000010; optab[5] = 6'b001000;
    n_tmo = 0;
    model_reset();
    do_reset();

    // R-type with memory always ready: IDLE FETCH DECODE EXEC RWB
    repeat (5) cycle(6'b000000, 1'b1);
    chk("rtype_done_cyc", 32'(last_done), 32'd5);

    // lw with three wait cycles in MEMRD; op wanders outside DECODE/MEMADR
    cycle(6'b000100, 1'b1);
    cycle(6'b100011, 1'b1);
    cycle(6'b100011, 1'b1);
    repeat (3) cycle(6'b000010, 1'b0);
    cycle(6'b111111, 1'b1);
    cycle(6'b000000, 1'b1);
    chk("lw_len", 32'(last_done - prev_done), 32'd8);

    // beq then j
    repeat (3) cycle(6'b000100, 1'b1);
    chk("beq_len", 32'(last_done - prev_done), 32'd3);
    repeat (3) cycle(6'b000010, 1'b1);
    chk("j_len", 32'(last_done - prev_done), 32'd3);

    // illegal opcode: FETCH, DECODE, back to FETCH
    repeat (2) cycle(6'b111111, 1'b1);
    chk("illegal_state", 32'(state), 32'(ST_FETCH));

    // sw watchdog: four dead cycles in MEMWR
    n_tmo = 0;
    repeat (3) cycle(6'b101011, 1'b1);
    repeat (4) cycle(6'b101011, 1'b0);
    chk("tmo_count", 32'(n_tmo), 32'd1);
    chk("tmo_state", 32'(state), 32'(ST_FETCH));
    chk("tmo_memwrite", 32'(memwrite), 32'd0);
    cycle(6'b000000, 1'b0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic [5:0] o;
      logic       r;
      if ($urandom_range(0, 7) < 6) o = optab[$urandom_range(0, 5)];
      else o = 6'($urandom);
      r = ($urandom_range(0, 9) < 7);
      cycle(o, r);
    end

    // async reset in the middle of a stalled sw
    do_reset();
    repeat (4) cycle(6'b101011, 1'b1);
    mem_ready = 1'b0;
    #1;
    chk("arst_pre_memwrite", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_memwrite", 32'(memwrite), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ctl", 32'(g_now), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (6) cycle(6'b001000, 1'b1);
    chk("addi_done_cyc", 32'(last_done), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
